// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : draw_scheduler
//  Purpose  : Shares the single vga_adapter pixel port between the four draw
//             clients (sky, catcher, score, gameover). On each frame tick it
//             grants the clients one at a time, waits for each one's finish
//             pulse, and forwards the granted client's x/y/colour/plot to the
//             adapter through a registered mux. A per-grant watchdog forces
//             the sequence forward if a client never finishes.
//  Ports    :
//    clock       in   1   system clock
//    reset       in   1   synchronous, active-low reset
//    frame_tick  in   1   one-cycle pulse that starts a frame
//    game_over   in   1   level; selects the end screen at the next tick
//    done        in   4   finish pulses {end,score,catcher,sky}
//    x_in        in   32  x buses, 8b each, {end,score,catcher,sky}
//    y_in        in   28  y buses, 7b each, same order
//    color_in    in   12  colour buses, 3b each, same order
//    plot_in     in   4   per-client write strobes, same order
//    grant       out  4   one-hot draw enable: b0 sky, b1 catcher, b2 score,
//                         b3 end
//    x/y/color   out      registered pixel coordinates and colour to adapter
//    plot        out  1   registered write strobe; 0 when nobody is granted
//    busy        out  1   high while a grant is active or in HALT
//    overrun     out  1   sticky: frame_tick seen while not idle
//    timeout_err out  1   sticky: a grant was ended by the watchdog
//  Revision : 1.0  initial release
// ============================================================================
module draw_scheduler #(
    parameter int TIMEOUT = 20000,
    parameter int TW      = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        game_over,
    input  logic [3:0]  done,
    input  logic [31:0] x_in,
    input  logic [27:0] y_in,
    input  logic [11:0] color_in,
    input  logic [3:0]  plot_in,
    output logic [3:0]  grant,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  color,
    output logic        plot,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SKY     = 3'd1,
        S_CATCHER = 3'd2,
        S_SCORE   = 3'd3,
        S_END     = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam logic [TW-1:0] C_WDOG_LAST = TW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_wdog;

    logic          w_granted;
    logic [1:0]    w_lane;
    logic          w_own_done;
    logic          w_expired;
    logic          w_advance;

    logic [7:0]    w_lane_x     [4];
    logic [6:0]    w_lane_y     [4];
    logic [2:0]    w_lane_color [4];

    // Split the packed client buses into per-client lanes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_x[gi]     = x_in[8*gi +: 8];
            assign w_lane_y[gi]     = y_in[7*gi +: 7];
            assign w_lane_color[gi] = color_in[3*gi +: 3];
        end
    endgenerate

    function automatic logic [3:0] grant_of(input state_t s);
        logic [3:0] g;
        g = 4'b0000;
        case (s)
            S_SKY:     g = 4'b0001;
            S_CATCHER: g = 4'b0010;
            S_SCORE:   g = 4'b0100;
            S_END:     g = 4'b1000;
            default:   g = 4'b0000;
        endcase
        return g;
    endfunction

    // Which client owns the port right now, and whether it is finishing.
    // done bits of any other client are deliberately ignored here.
    always_comb begin
        w_granted  = 1'b0;
        w_lane     = 2'd0;
        w_own_done = 1'b0;
        case (r_state)
            S_SKY: begin
                w_granted  = 1'b1;
                w_lane     = 2'd0;
                w_own_done = done[0];
            end
            S_CATCHER: begin
                w_granted  = 1'b1;
                w_lane     = 2'd1;
                w_own_done = done[1];
            end
            S_SCORE: begin
                w_granted  = 1'b1;
                w_lane     = 2'd2;
                w_own_done = done[2];
            end
            S_END: begin
                w_granted  = 1'b1;
                w_lane     = 2'd3;
                w_own_done = done[3];
            end
            default: begin
                w_granted  = 1'b0;
                w_lane     = 2'd0;
                w_own_done = 1'b0;
            end
        endcase
    end

    // The watchdog counts from 0 on grant entry, so reaching TIMEOUT-1 means
    // the grant has been held for exactly TIMEOUT cycles once we leave.
    assign w_expired = w_granted && (r_wdog == C_WDOG_LAST);
    assign w_advance = w_own_done || w_expired;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_tick) begin
                    w_next = game_over ? S_END : S_SKY;
                end
            end
            S_SKY:     if (w_advance) w_next = S_CATCHER;
            S_CATCHER: if (w_advance) w_next = S_SCORE;
            S_SCORE:   if (w_advance) w_next = S_IDLE;
            S_END:     if (w_advance) w_next = S_HALT;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_IDLE;
        endcase
    end

    // State, grant/busy (decoded from the next state so they line up with
    // the state register), watchdog, sticky flags and the output mux.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wdog      <= '0;
            grant       <= 4'b0000;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            x           <= 8'd0;
            y           <= 7'd0;
            color       <= 3'd0;
            plot        <= 1'b0;
        end else begin
            r_state <= w_next;
            grant   <= grant_of(w_next);
            busy    <= (w_next != S_IDLE);

            if (w_next != r_state) begin
                r_wdog <= '0;
            end else if (w_granted) begin
                r_wdog <= r_wdog + 1'b1;
            end

            // A tick that lands on the SCORE finish cycle is still "not idle".
            if (frame_tick && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            // A finish pulse on the expiry cycle wins; no error is flagged.
            if (w_expired && !w_own_done) begin
                timeout_err <= 1'b1;
            end

            // Pixel bus holds its last value when nobody owns the port.
            if (w_granted) begin
                x     <= w_lane_x[w_lane];
                y     <= w_lane_y[w_lane];
                color <= w_lane_color[w_lane];
                plot  <= plot_in[w_lane];
            end else begin
                plot  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
